// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch unit.
// Holds the fetch FSM state encoding, the zero instruction and the byte-offset helper.
package imem_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } imem_state_e;

    // Wide zero constant, cast down to the instruction width at the use site.
    localparam logic [63:0] IMEM_NOP = 64'h0;

    // Number of PC bits that select a byte within one instruction word.
    function automatic int imem_off(input int instr_width);
        return $clog2(instr_width / 8);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous read port and one write port.
// A read and a write to the same word on one edge return the old contents.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write and registered read; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: request/busy handshake, programmable read latency,
// single-entry last-fetch hit path and misaligned/out-of-range fault flagging.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int INSTR_WIDTH  = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [ADDR_WIDTH-1:0]      PC,
    input  logic                       READ,
    output logic [INSTR_WIDTH-1:0]     INSTRUCTION,
    output logic                       BUSY,
    output logic                       FAULT,
    input  logic                       LOAD_EN,
    input  logic [$clog2(DEPTH)-1:0]   LOAD_ADDR,
    input  logic [INSTR_WIDTH-1:0]     LOAD_DATA
);

    localparam int OFF = imem_off(INSTR_WIDTH);
    localparam int IW  = $clog2(DEPTH);
    localparam int CW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [CW-1:0]         CNT_INIT = CW'(READ_LATENCY - 1);
    localparam logic [INSTR_WIDTH-1:0] ZERO_I  = INSTR_WIDTH'(IMEM_NOP);

    imem_state_e              state_r, state_s;
    logic [ADDR_WIDTH-1:0]    word_s;
    logic                     err_s, hit_s, wr_tag_s, wr_cap_s, wr_new_s, arr_re_s;
    logic [INSTR_WIDTH-1:0]   arr_rdata_s;
    logic [INSTR_WIDTH-1:0]   instr_r, instr_s;
    logic                     busy_r, busy_s, fault_r, fault_s;
    logic                     hit_valid_r, hit_valid_s, stale_r, stale_s;
    logic [CW-1:0]            cnt_r, cnt_s;
    logic [IW-1:0]            cap_idx_r, cap_idx_s, tag_idx_r, tag_idx_s;
    logic [ADDR_WIDTH-1:0]    cap_pc_r, cap_pc_s, tag_r, tag_s;

    assign word_s   = PC >> OFF;
    assign err_s    = (|(PC & OFF_MASK)) || (word_s >= DEPTH_A);
    assign hit_s    = hit_valid_r && (PC == tag_r);
    assign wr_tag_s = LOAD_EN && (LOAD_ADDR == tag_idx_r);
    assign wr_cap_s = LOAD_EN && (LOAD_ADDR == cap_idx_r);
    assign wr_new_s = LOAD_EN && (LOAD_ADDR == word_s[IW-1:0]);

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_WIDTH),
        .AW    (IW)
    ) u_array (
        .clk   (CLK),
        .we    (LOAD_EN),
        .waddr (LOAD_ADDR),
        .wdata (LOAD_DATA),
        .re    (arr_re_s),
        .raddr (word_s[IW-1:0]),
        .rdata (arr_rdata_s)
    );

    // Next-state and next-register values for the fetch FSM
    always_comb begin
        state_s     = state_r;
        instr_s     = instr_r;
        busy_s      = busy_r;
        fault_s     = fault_r;
        cnt_s       = cnt_r;
        cap_idx_s   = cap_idx_r;
        cap_pc_s    = cap_pc_r;
        tag_s       = tag_r;
        tag_idx_s   = tag_idx_r;
        hit_valid_s = hit_valid_r && !wr_tag_s;
        stale_s     = stale_r;
        arr_re_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (READ) begin
                    if (err_s) begin
                        fault_s     = 1'b1;
                        instr_s     = ZERO_I;
                        hit_valid_s = 1'b0;
                    end else if (hit_s) begin
                        fault_s     = 1'b0;
                    end else begin
                        fault_s   = 1'b0;
                        busy_s    = 1'b1;
                        cnt_s     = CNT_INIT;
                        cap_idx_s = word_s[IW-1:0];
                        cap_pc_s  = PC;
                        stale_s   = wr_new_s;
                        arr_re_s  = 1'b1;
                        state_s   = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                // The word was read at accept; any later write to it makes the result stale.
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s   = cnt_r - CW'(1);
                    stale_s = stale_r || wr_cap_s;
                end else begin
                    instr_s     = arr_rdata_s;
                    tag_s       = cap_pc_r;
                    tag_idx_s   = cap_idx_r;
                    hit_valid_s = !(stale_r || wr_cap_s);
                    stale_s     = 1'b0;
                    busy_s      = 1'b0;
                    state_s     = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            instr_r     <= ZERO_I;
            busy_r      <= 1'b0;
            fault_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            cap_idx_r   <= {IW{1'b0}};
            cap_pc_r    <= {ADDR_WIDTH{1'b0}};
            tag_r       <= {ADDR_WIDTH{1'b0}};
            tag_idx_r   <= {IW{1'b0}};
            hit_valid_r <= 1'b0;
            stale_r     <= 1'b0;
        end else begin
            instr_r     <= instr_s;
            busy_r      <= busy_s;
            fault_r     <= fault_s;
            cnt_r       <= cnt_s;
            cap_idx_r   <= cap_idx_s;
            cap_pc_r    <= cap_pc_s;
            tag_r       <= tag_s;
            tag_idx_r   <= tag_idx_s;
            hit_valid_r <= hit_valid_s;
            stale_r     <= stale_s;
        end
    end

    assign INSTRUCTION = instr_r;
    assign BUSY        = busy_r;
    assign FAULT       = fault_r;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: three instances (latency 1, 2, 4) share stimulus;
// a vector table drives the latency-2 instance, hand sequences cover reset, in-flight writes and sweeps.
module tb_imem_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic        READ;
    logic        LOAD_EN;
    logic [7:0]  LOAD_ADDR;
    logic [31:0] LOAD_DATA;

    logic [31:0] instr1, instr2, instr4;
    logic        busy1, busy2, busy4, fault1, fault2, fault4;
    logic [31:0] cur_instr;
    logic        cur_busy, cur_fault;

    int          sel;
    int          n_cmp;
    int          n_bad;
    logic [31:0] model_mem [256];

    typedef struct {
        logic        do_load;
        logic [7:0]  ld_addr;
        logic [31:0] ld_data;
        logic [31:0] pc;
        int          exp_lat;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [11];

    imem_fetch_unit #(.READ_LATENCY(1)) u_rl1 (
        .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ), .INSTRUCTION(instr1),
        .BUSY(busy1), .FAULT(fault1), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA));
    imem_fetch_unit #(.READ_LATENCY(2)) u_rl2 (
        .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ), .INSTRUCTION(instr2),
        .BUSY(busy2), .FAULT(fault2), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA));
    imem_fetch_unit #(.READ_LATENCY(4)) u_rl4 (
        .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ), .INSTRUCTION(instr4),
        .BUSY(busy4), .FAULT(fault4), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA));

    assign cur_instr = (sel == 1) ? instr1 : ((sel == 4) ? instr4 : instr2);
    assign cur_busy  = (sel == 1) ? busy1  : ((sel == 4) ? busy4  : busy2);
    assign cur_fault = (sel == 1) ? fault1 : ((sel == 4) ? fault4 : fault2);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = idx;
        LOAD_DATA = data;
        step();
        LOAD_EN   = 1'b0;
        model_mem[idx] = data;
    endtask

    // One request pulse; returns how many edges after the accept edge BUSY stayed high.
    task automatic do_fetch(input logic [31:0] pc, output int lat);
        PC   = pc;
        READ = 1'b1;
        step();
        READ = 1'b0;
        lat  = 0;
        while (cur_busy === 1'b1 && lat < 16) begin
            step();
            lat = lat + 1;
        end
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        step();
    endtask

    task automatic sweep(input int rl);
        int lat;
        sel = rl;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            PC   = 32'(i * 4);
            READ = 1'b1;
            step();
            check($sformatf("sweep%0d_busy_up_%0d", rl, i), 32'(cur_busy), 32'd1);
            PC  = 32'h0000_0002;
            lat = 0;
            while (cur_busy === 1'b1 && lat < 16) begin
                step();
                lat = lat + 1;
            end
            check($sformatf("sweep%0d_lat_%0d", rl, i), 32'(lat), 32'(rl));
            check($sformatf("sweep%0d_instr_%0d", rl, i), cur_instr, model_mem[i]);
            check($sformatf("sweep%0d_fault_%0d", rl, i), 32'(cur_fault), 32'd0);
        end
        READ = 1'b0;
        step();
    endtask

    initial begin
        int lat;
        n_cmp     = 0;
        n_bad     = 0;
        sel       = 2;
        RESET     = 1'b0;
        PC        = 32'h0;
        READ      = 1'b0;
        LOAD_EN   = 1'b0;
        LOAD_ADDR = 8'h0;
        LOAD_DATA = 32'h0;

        vecs[0]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0000, 2, 32'h0004_0005, 1'b0};
        vecs[1]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0000, 0, 32'h0004_0005, 1'b0};
        vecs[2]  = '{1'b1, 8'd0, 32'hDEAD_BEEF, 32'h0000_0000, 2, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0002, 0, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0400, 0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0000, 2, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0008, 2, 32'h0206_0402, 1'b0};
        vecs[7]  = '{1'b0, 8'd0, 32'h0,        32'h0000_0008, 0, 32'h0206_0402, 1'b0};
        vecs[8]  = '{1'b0, 8'd0, 32'h0,        32'h0000_000C, 2, 32'h0100_0006, 1'b0};
        vecs[9]  = '{1'b0, 8'd0, 32'h0,        32'h0000_03FC, 2, 32'hC0DE_00FF, 1'b0};
        vecs[10] = '{1'b0, 8'd0, 32'h0,        32'h0000_0000, 2, 32'hDEAD_BEEF, 1'b0};

        @(negedge CLK);
        step();
        check("reset_instr", cur_instr, 32'h0);
        check("reset_busy", 32'(cur_busy), 32'd0);
        check("reset_fault", 32'(cur_fault), 32'd0);
        RESET = 1'b1;
        step();

        for (int i = 0; i < 256; i++) begin
            load_word(8'(i), 32'hC0DE_0000 + 32'(i));
        end
        load_word(8'd0, 32'h0004_0005);
        load_word(8'd1, 32'h0002_0009);
        load_word(8'd2, 32'h0206_0402);
        load_word(8'd3, 32'h0100_0006);
        load_word(8'd4, 32'h0001_0001);
        load_word(8'd5, 32'h0202_0201);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_load) begin
                load_word(vecs[i].ld_addr, vecs[i].ld_data);
            end
            do_fetch(vecs[i].pc, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_instr", i), cur_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_fault", i), 32'(cur_fault), 32'(vecs[i].exp_fault));
            check($sformatf("vec%0d_busy_low", i), 32'(cur_busy), 32'd0);
        end

        // Reset one cycle into a fetch aborts it and clears outputs asynchronously.
        PC   = 32'h0000_0004;
        READ = 1'b1;
        step();
        READ = 1'b0;
        check("abort_busy_before", 32'(cur_busy), 32'd1);
        RESET = 1'b0;
        #1;
        check("abort_busy", 32'(cur_busy), 32'd0);
        check("abort_instr", cur_instr, 32'h0);
        check("abort_fault", 32'(cur_fault), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        step();
        do_fetch(32'h0000_0004, lat);
        check("after_abort_lat", 32'(lat), 32'd2);
        check("after_abort_instr", cur_instr, 32'h0002_0009);

        // Write to the in-flight word: old data returned, tag not kept.
        PC   = 32'h0000_0010;
        READ = 1'b1;
        step();
        READ      = 1'b0;
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 8'd4;
        LOAD_DATA = 32'h1111_1111;
        step();
        LOAD_EN = 1'b0;
        model_mem[4] = 32'h1111_1111;
        check("inflight_busy", 32'(cur_busy), 32'd1);
        step();
        check("inflight_done", 32'(cur_busy), 32'd0);
        check("inflight_old", cur_instr, 32'h0001_0001);
        do_fetch(32'h0000_0010, lat);
        check("inflight_refetch_lat", 32'(lat), 32'd2);
        check("inflight_refetch_instr", cur_instr, 32'h1111_1111);

        sweep(1);
        sweep(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
